// File: rtl/s_iter_div_pe.sv
// Iterative restoring divider PE: DIV/REM/DIVU, one quotient bit per cycle.
// Ports: clk_i/rst_n_i, mage_done_i clear, pea_ready_i advance, instr_i,
//   a_i/b_i + valids, delay_i line, ready_o, valid_o/res_o/rem_q_o, busy_o.
module s_iter_div_pe #(
  parameter int WIDTH       = 32,
  parameter int DELAY_DEPTH = 2,
  parameter int ACC_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             mage_done_i,
  input  logic             pea_ready_i,
  input  logic [1:0]       instr_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             a_valid_i,
  input  logic             b_valid_i,
  input  logic [WIDTH-1:0] delay_i,
  input  logic             delay_valid_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] res_o,
  output logic [WIDTH-1:0] rem_q_o,
  output logic [WIDTH-1:0] delay_o,
  output logic             delay_valid_o,
  output logic             busy_o
);

  // ACC_W belongs to the array-level accumulate count; no port here.
  localparam int CNT_W = $clog2(WIDTH + 1) + 0 * ACC_W;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sec_q, sec_d;
  logic             nq_q, nq_d;
  logic             nr_q, nr_d;
  logic             isrem_q, isrem_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0]   dly_q [DELAY_DEPTH];
  logic [WIDTH-1:0]   dly_d [DELAY_DEPTH];
  logic [DELAY_DEPTH-1:0] dv_q, dv_d;

  logic             op_signed;
  logic             op_rem;
  logic             a_neg;
  logic             b_neg;
  logic             ovf;
  logic             div0;
  logic             accept;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] sp_quo;
  logic [WIDTH-1:0] sp_rem;
  logic [WIDTH:0]   shifted;
  logic             take;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] fin_quo;
  logic [WIDTH-1:0] fin_rem;

  assign op_signed = instr_i != OP_DIVU;
  assign op_rem    = instr_i == OP_REM;
  assign a_neg     = op_signed & a_i[WIDTH-1];
  assign b_neg     = op_signed & b_i[WIDTH-1];
  assign a_abs     = a_neg ? -a_i : a_i;
  assign b_abs     = b_neg ? -b_i : b_i;
  assign div0      = b_i == '0;
  assign ovf       = op_signed & (a_i == MOST_NEG) & (b_i == '1);
  assign sp_quo    = div0 ? '1 : a_i;
  assign sp_rem    = div0 ? a_i : '0;

  assign ready_o = (state_q == S_IDLE) & (instr_i != OP_NOP)
                 & !mage_done_i;
  assign accept  = ready_o & a_valid_i & b_valid_i & pea_ready_i;

  // Restoring step: the trial remainder needs one extra bit.
  assign shifted  = {prem_q, quo_q[WIDTH-1]};
  assign take     = shifted >= {1'b0, dvs_q};
  // When taken the difference is below the divisor, so WIDTH bits suffice.
  assign diff     = shifted[WIDTH-1:0] - dvs_q;
  assign step_rem = take ? diff : shifted[WIDTH-1:0];
  assign step_quo = {quo_q[WIDTH-2:0], take};
  assign fin_quo  = nq_q ? -step_quo : step_quo;
  assign fin_rem  = nr_q ? -step_rem : step_rem;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    prem_d  = prem_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    sec_d   = sec_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    isrem_d = isrem_q;
    valid_d = valid_q;
    if (mage_done_i || instr_i == OP_NOP) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      res_d   = '0;
      sec_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            quo_d   = a_abs;
            prem_d  = '0;
            dvs_d   = b_abs;
            nq_d    = a_neg ^ b_neg;
            nr_d    = a_neg;
            isrem_d = op_rem;
            if (div0 || ovf) begin
              state_d = S_DONE;
              cnt_d   = '0;
              valid_d = 1'b1;
              res_d   = op_rem ? sp_rem : sp_quo;
              sec_d   = op_rem ? sp_quo : sp_rem;
            end else begin
              state_d = S_BUSY;
              cnt_d   = CNT_W'(WIDTH);
            end
          end
        end
        S_BUSY: begin
          quo_d  = step_quo;
          prem_d = step_rem;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_DONE;
            valid_d = 1'b1;
            res_d   = isrem_q ? fin_rem : fin_quo;
            sec_d   = isrem_q ? fin_quo : fin_rem;
          end
        end
        S_DONE: begin
          if (pea_ready_i) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    dly_d = dly_q;
    dv_d  = dv_q;
    if (mage_done_i) begin
      for (int i = 0; i < DELAY_DEPTH; i++) dly_d[i] = '0;
      dv_d = '0;
    end else if (pea_ready_i) begin
      dly_d[0] = delay_i;
      dv_d[0]  = delay_valid_i;
      for (int i = 1; i < DELAY_DEPTH; i++) begin
        dly_d[i] = dly_q[i-1];
        dv_d[i]  = dv_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      prem_q  <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      sec_q   <= '0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      isrem_q <= 1'b0;
      valid_q <= 1'b0;
      dv_q    <= '0;
      for (int i = 0; i < DELAY_DEPTH; i++) dly_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      prem_q  <= prem_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      sec_q   <= sec_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
      isrem_q <= isrem_d;
      valid_q <= valid_d;
      dv_q    <= dv_d;
      for (int i = 0; i < DELAY_DEPTH; i++) dly_q[i] <= dly_d[i];
    end
  end

  assign valid_o       = valid_q;
  assign res_o         = res_q;
  assign rem_q_o       = sec_q;
  assign busy_o        = state_q == S_BUSY;
  assign delay_o       = dly_q[DELAY_DEPTH-1];
  assign delay_valid_o = dv_q[DELAY_DEPTH-1];

endmodule

// File: tb/tb_s_iter_div_pe.sv
// Bench for s_iter_div_pe (WIDTH=8, DELAY_DEPTH=2).
// Vector table + model-driven random ops, scoreboard queue, corner sequences.
module tb_s_iter_div_pe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mage_done = 1'b0;
  logic         pea_ready = 1'b0;
  logic [1:0]   instr = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         a_valid = 1'b0;
  logic         b_valid = 1'b0;
  logic [W-1:0] delay_i = '0;
  logic         delay_valid_i = 1'b0;
  logic         ready_o;
  logic         valid_o;
  logic [W-1:0] res_o;
  logic [W-1:0] rem_q_o;
  logic [W-1:0] delay_o;
  logic         delay_valid_o;
  logic         busy_o;

  s_iter_div_pe #(
    .WIDTH(W),
    .DELAY_DEPTH(2),
    .ACC_W(16)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .mage_done_i(mage_done),
    .pea_ready_i(pea_ready),
    .instr_i(instr),
    .a_i(a),
    .b_i(b),
    .a_valid_i(a_valid),
    .b_valid_i(b_valid),
    .delay_i(delay_i),
    .delay_valid_i(delay_valid_i),
    .ready_o(ready_o),
    .valid_o(valid_o),
    .res_o(res_o),
    .rem_q_o(rem_q_o),
    .delay_o(delay_o),
    .delay_valid_o(delay_valid_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   instr;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] sec;
    int           lat;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[12];
  int   nchk = 0;
  int   nfail = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [1:0] ins,
                                 input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    vec_t v;
    logic [W-1:0] q;
    logic [W-1:0] r;
    int sa;
    int sb;
    v.instr = ins;
    v.a = x;
    v.b = y;
    if (y == 0) begin
      q = '1; r = x; v.lat = 1;
    end else if (ins != 2'b11 && x == 8'h80 && y == 8'hFF) begin
      q = 8'h80; r = '0; v.lat = 1;
    end else if (ins == 2'b11) begin
      q = x / y; r = x % y; v.lat = 9;
    end else begin
      sa = $signed(x);
      sb = $signed(y);
      q = 8'(sa / sb);
      r = 8'(sa % sb);
      v.lat = 9;
    end
    v.res = (ins == 2'b10) ? r : q;
    v.sec = (ins == 2'b10) ? q : r;
    return v;
  endfunction

  // Sample at the current negedge, then step; bounded.
  task automatic wait_valid(output logic seen, output int lat,
                            output int busy_n);
    seen = 1'b0;
    lat = 1;
    busy_n = 0;
    while (!seen && lat <= 20) begin
      if (valid_o) begin
        seen = 1'b1;
      end else begin
        if (busy_o) busy_n++;
        lat++;
        @(negedge clk);
      end
    end
  endtask

  task automatic run_op(input vec_t v);
    logic seen;
    int lat;
    int bn;
    vec_t e;
    exp_q.push_back(v);
    @(negedge clk);
    instr = v.instr; a = v.a; b = v.b;
    a_valid = 1'b1; b_valid = 1'b1; pea_ready = 1'b1;
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    wait_valid(seen, lat, bn);
    e = exp_q.pop_front();
    check("op_seen", 64'(seen), 64'd1);
    if (seen) begin
      check("op_res", 64'(res_o), 64'(e.res));
      check("op_sec", 64'(rem_q_o), 64'(e.sec));
      check("op_lat", 64'(lat), 64'(e.lat));
      check("op_busy", 64'(bn), (e.lat == 9) ? 64'd8 : 64'd0);
    end
  endtask

  initial begin : wd
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic seen;
    int lat;
    int bn;
    int vcnt;
    tbl[0]  = '{2'b01, 8'd100, 8'd7,  8'd14,  8'd2,   9};
    tbl[1]  = '{2'b10, 8'hF9,  8'd2,  8'hFF,  8'hFD,  9};
    tbl[2]  = '{2'b11, 8'hF9,  8'd2,  8'd124, 8'd1,   9};
    tbl[3]  = '{2'b01, 8'd5,   8'd0,  8'hFF,  8'd5,   1};
    tbl[4]  = '{2'b01, 8'h80,  8'hFF, 8'h80,  8'h00,  1};
    tbl[5]  = '{2'b10, 8'h80,  8'hFF, 8'h00,  8'h80,  1};
    tbl[6]  = '{2'b11, 8'h80,  8'hFF, 8'h00,  8'h80,  9};
    tbl[7]  = '{2'b01, 8'h9C,  8'd7,  8'hF2,  8'hFE,  9};
    tbl[8]  = '{2'b01, 8'd100, 8'hF9, 8'hF2,  8'd2,   9};
    tbl[9]  = '{2'b10, 8'd5,   8'd0,  8'd5,   8'hFF,  1};
    tbl[10] = '{2'b11, 8'hFF,  8'd1,  8'hFF,  8'h00,  9};
    tbl[11] = '{2'b01, 8'h7F,  8'd1,  8'h7F,  8'h00,  9};

    repeat (3) @(negedge clk);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_res", 64'(res_o), 64'd0);
    check("rst_sec", 64'(rem_q_o), 64'd0);
    check("rst_dly", 64'(delay_o), 64'd0);
    check("rst_dlyv", 64'(delay_valid_o), 64'd0);
    check("rst_ready_nop", 64'(ready_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    instr = 2'b01;
    #1 check("ready_div", 64'(ready_o), 64'd1);
    mage_done = 1'b1;
    #1 check("ready_mage", 64'(ready_o), 64'd0);
    mage_done = 1'b0;

    foreach (tbl[i]) run_op(tbl[i]);
    for (int i = 0; i < 10; i++)
      run_op(model(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom)));

    // Stall in DONE
    @(negedge clk);
    instr = 2'b01; a = 8'd100; b = 8'd7;
    a_valid = 1'b1; b_valid = 1'b1; pea_ready = 1'b1;
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; pea_ready = 1'b0;
    wait_valid(seen, lat, bn);
    check("stall_seen", 64'(seen), 64'd1);
    check("stall_lat", 64'(lat), 64'd9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(valid_o), 64'd1);
      check("stall_res", 64'(res_o), 64'd14);
      check("stall_ready", 64'(ready_o), 64'd0);
    end
    pea_ready = 1'b1;
    @(negedge clk);
    check("rel_valid", 64'(valid_o), 64'd0);
    check("rel_ready", 64'(ready_o), 64'd1);
    check("rel_res_hold", 64'(res_o), 64'd14);
    check("rel_sec_hold", 64'(rem_q_o), 64'd2);

    // mage_done mid-BUSY
    delay_i = 8'h5A; delay_valid_i = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    check("mage_busy_pre", 64'(busy_o), 64'd1);
    @(negedge clk);
    @(negedge clk);
    check("mage_dlyv_pre", 64'(delay_valid_o), 64'd1);
    mage_done = 1'b1;
    @(negedge clk);
    mage_done = 1'b0; delay_valid_i = 1'b0;
    check("mage_busy", 64'(busy_o), 64'd0);
    check("mage_valid", 64'(valid_o), 64'd0);
    check("mage_res", 64'(res_o), 64'd0);
    check("mage_sec", 64'(rem_q_o), 64'd0);
    check("mage_dlyv", 64'(delay_valid_o), 64'd0);
    check("mage_dly", 64'(delay_o), 64'd0);
    vcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (valid_o) vcnt++;
    end
    check("mage_no_result", 64'(vcnt), 64'd0);

    // Delay line with stall
    delay_i = 8'h11; delay_valid_i = 1'b1;
    @(negedge clk);
    delay_i = 8'h22;
    @(negedge clk);
    check("dly_11", 64'(delay_o), 64'h11);
    check("dly_11_v", 64'(delay_valid_o), 64'd1);
    pea_ready = 1'b0; delay_i = 8'h33;
    @(negedge clk);
    check("dly_hold", 64'(delay_o), 64'h11);
    check("dly_hold_v", 64'(delay_valid_o), 64'd1);
    pea_ready = 1'b1;
    @(negedge clk);
    check("dly_22", 64'(delay_o), 64'h22);
    delay_valid_i = 1'b0;

    // NOP clears result
    run_op(tbl[0]);
    @(negedge clk);
    instr = 2'b00;
    @(negedge clk);
    check("nop_ready", 64'(ready_o), 64'd0);
    check("nop_res", 64'(res_o), 64'd0);
    check("nop_sec", 64'(rem_q_o), 64'd0);
    check("nop_valid", 64'(valid_o), 64'd0);

    // Async reset mid-BUSY, then a clean operation
    run_op(tbl[7]);
    @(negedge clk);
    instr = 2'b01; a = 8'd100; b = 8'd7;
    a_valid = 1'b1; b_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy_o), 64'd0);
    check("arst_res", 64'(res_o), 64'd0);
    check("arst_valid", 64'(valid_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(tbl[1]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
